// File: rtl/axi_dma_pkg.sv
// Shared definitions for the AXI DMA write-channel control block:
// register offsets, bit positions, FSM states and the transfer descriptor.
package axi_dma_pkg;

  localparam int unsigned ADDR_CR      = 'h00;
  localparam int unsigned ADDR_SRC_LSB = 'h04;
  localparam int unsigned ADDR_SRC_MSB = 'h08;
  localparam int unsigned ADDR_DST_LSB = 'h0C;
  localparam int unsigned ADDR_DST_MSB = 'h10;
  localparam int unsigned ADDR_LEN     = 'h14;
  localparam int unsigned ADDR_SR      = 'h18;

  localparam int CR_START  = 0;
  localparam int CR_IRQ_EN = 1;
  localparam int SR_BUSY   = 0;
  localparam int SR_DONE   = 1;
  localparam int SR_ERR    = 2;

  typedef enum logic [1:0] {IDLE, REQ, BUSY} TYPE_DMA_STATE;

  typedef struct packed {
    logic [63:0] src;
    logic [63:0] dst;
    logic [31:0] len;
  } dma_desc_t;

endpackage

// File: rtl/axi_dma_w_ctrl.sv
// APB3 register front-end for the DMA write engine: register file, APB decode,
// descriptor launch FSM and done/err status with a level interrupt.
module axi_dma_w_ctrl
  import axi_dma_pkg::*;
#(
  parameter int APB_AW = 12,
  parameter int AXI_AW = 32,
  parameter int RAM_AW = 20
) (
  input  logic              apb_clk,
  input  logic              apb_reset_n,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [APB_AW-1:0] paddr,
  input  logic [31:0]       pwdata,
  output logic [31:0]       prdata,
  output logic              pready,
  output logic              pslverr,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [RAM_AW-1:0] cmd_src,
  output logic [AXI_AW-1:0] cmd_dst,
  output logic [31:0]       cmd_len,
  input  logic              dma_done,
  input  logic              dma_err,
  output logic              irq
);

  TYPE_DMA_STATE state, state_nxt;

  logic        cr_irq_en;
  logic [31:0] src_lsb, src_msb, dst_lsb, dst_msb, len;
  logic        sr_done, sr_err;
  logic [31:0] dst_msb_rd;
  dma_desc_t   desc;

  logic [APB_AW-1:0] word_addr;
  logic access, wr, rd, busy, cfg_wr, cfg_sel, mapped, start_cmd, len_zero;
  logic sel_cr, sel_src_l, sel_src_m, sel_dst_l, sel_dst_m, sel_len, sel_sr;
  logic done_set, done_clr, err_set, err_clr;

  assign word_addr = paddr & ~APB_AW'(3);
  assign sel_cr    = (word_addr == APB_AW'(ADDR_CR));
  assign sel_src_l = (word_addr == APB_AW'(ADDR_SRC_LSB));
  assign sel_src_m = (word_addr == APB_AW'(ADDR_SRC_MSB));
  assign sel_dst_l = (word_addr == APB_AW'(ADDR_DST_LSB));
  assign sel_dst_m = (word_addr == APB_AW'(ADDR_DST_MSB));
  assign sel_len   = (word_addr == APB_AW'(ADDR_LEN));
  assign sel_sr    = (word_addr == APB_AW'(ADDR_SR));
  assign cfg_sel   = sel_cr | sel_src_l | sel_src_m | sel_dst_l | sel_dst_m | sel_len;
  assign mapped    = cfg_sel | sel_sr;

  assign access    = psel & penable;
  assign wr        = access & pwrite;
  assign rd        = access & ~pwrite;
  assign busy      = (state != IDLE);
  // Configuration is frozen while a transfer is in flight so cmd_* stay stable.
  assign cfg_wr    = wr & ~busy;
  assign len_zero  = (len == 32'd0);
  assign start_cmd = cfg_wr & sel_cr & pwdata[CR_START];

  assign pready  = 1'b1;
  assign pslverr = access & (~mapped | (pwrite & busy & cfg_sel));

  assign dst_msb_rd = (AXI_AW > 32) ? dst_msb : 32'd0;
  assign desc       = '{src: {src_msb, src_lsb}, dst: {dst_msb_rd, dst_lsb}, len: len};
  assign cmd_src    = RAM_AW'(desc.src);
  assign cmd_dst    = AXI_AW'(desc.dst);
  assign cmd_len    = desc.len;
  assign cmd_valid  = (state == REQ);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_cmd && !len_zero) state_nxt = REQ;
      REQ:     if (cmd_ready) state_nxt = BUSY;
      BUSY:    if (dma_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge apb_clk or negedge apb_reset_n) begin
    if (!apb_reset_n) state <= IDLE;
    else              state <= state_nxt;
  end

  // Status events take priority over a W1C landing in the same cycle.
  assign done_set = (start_cmd & len_zero) | ((state == BUSY) & dma_done);
  assign err_set  = (state == BUSY) & dma_err;
  assign done_clr = (wr & sel_sr & pwdata[SR_DONE]) | (start_cmd & ~len_zero);
  assign err_clr  = (wr & sel_sr & pwdata[SR_ERR])  | (start_cmd & ~len_zero);

  always_ff @(posedge apb_clk or negedge apb_reset_n) begin
    if (!apb_reset_n) begin
      cr_irq_en <= 1'b0;
      src_lsb   <= '0;
      src_msb   <= '0;
      dst_lsb   <= '0;
      dst_msb   <= '0;
      len       <= '0;
      sr_done   <= 1'b0;
      sr_err    <= 1'b0;
      irq       <= 1'b0;
    end else begin
      if (cfg_wr && sel_cr)    cr_irq_en <= pwdata[CR_IRQ_EN];
      if (cfg_wr && sel_src_l) src_lsb   <= pwdata;
      if (cfg_wr && sel_src_m) src_msb   <= pwdata;
      if (cfg_wr && sel_dst_l) dst_lsb   <= pwdata;
      if (cfg_wr && sel_dst_m && AXI_AW > 32) dst_msb <= pwdata;
      if (cfg_wr && sel_len)   len       <= pwdata;
      if (done_set)      sr_done <= 1'b1;
      else if (done_clr) sr_done <= 1'b0;
      if (err_set)       sr_err  <= 1'b1;
      else if (err_clr)  sr_err  <= 1'b0;
      irq <= cr_irq_en & (sr_done | sr_err);
    end
  end

  always_comb begin
    prdata = 32'd0;
    if (rd) begin
      if (sel_cr)    prdata = {30'd0, cr_irq_en, 1'b0};
      if (sel_src_l) prdata = src_lsb;
      if (sel_src_m) prdata = src_msb;
      if (sel_dst_l) prdata = dst_lsb;
      if (sel_dst_m) prdata = dst_msb_rd;
      if (sel_len)   prdata = len;
      if (sel_sr)    prdata = {29'd0, sr_err, sr_done, busy};
    end
  end

endmodule

// File: tb/tb_axi_dma_w_ctrl.sv
// Directed bench for axi_dma_w_ctrl: register table sweep plus launch/status/reset sequences.
module tb_axi_dma_w_ctrl;

  logic        apb_clk = 1'b0;
  logic        apb_reset_n = 1'b0;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [11:0] paddr = '0;
  logic [31:0] pwdata = '0;
  logic [31:0] prdata;
  logic        pready, pslverr;
  logic        cmd_valid;
  logic        cmd_ready = 1'b0;
  logic [19:0] cmd_src;
  logic [31:0] cmd_dst;
  logic [31:0] cmd_len;
  logic        dma_done = 1'b0, dma_err = 1'b0;
  logic        irq;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 apb_clk = ~apb_clk;

  axi_dma_w_ctrl #(.APB_AW(12), .AXI_AW(32), .RAM_AW(20)) dut (
    .apb_clk(apb_clk), .apb_reset_n(apb_reset_n),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_src(cmd_src),
    .cmd_dst(cmd_dst), .cmd_len(cmd_len), .dma_done(dma_done),
    .dma_err(dma_err), .irq(irq)
  );

  typedef struct {
    logic        wr;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic        chk_rd;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t tbl[23];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic apb(input logic wr, input logic [11:0] addr, input logic [31:0] data,
                     input logic done_p, input logic err_p,
                     output logic [31:0] rd, output logic err);
    @(negedge apb_clk);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data;
    @(negedge apb_clk);
    penable = 1'b1; dma_done = done_p; dma_err = err_p;
    #1;
    rd = prdata; err = pslverr;
    @(posedge apb_clk);
    #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; dma_done = 1'b0; dma_err = 1'b0;
  endtask

  task automatic wr_reg(input string name, input logic [11:0] addr, input logic [31:0] data,
                        input logic exp_err);
    logic [31:0] rd;
    logic err;
    apb(1'b1, addr, data, 1'b0, 1'b0, rd, err);
    check({name, ".pslverr"}, 64'(err), 64'(exp_err));
  endtask

  task automatic rd_chk(input string name, input logic [11:0] addr, input logic [31:0] exp);
    logic [31:0] rd;
    logic err;
    apb(1'b0, addr, 32'd0, 1'b0, 1'b0, rd, err);
    check(name, 64'(rd), 64'(exp));
  endtask

  task automatic handshake();
    @(negedge apb_clk);
    cmd_ready = 1'b1;
    @(posedge apb_clk);
    #1;
    cmd_ready = 1'b0;
  endtask

  task automatic run_vec(input int i);
    logic [31:0] rd;
    logic err;
    apb(tbl[i].wr, tbl[i].addr, tbl[i].wdata, 1'b0, 1'b0, rd, err);
    check($sformatf("vec%0d.pslverr", i), 64'(err), 64'(tbl[i].exp_err));
    if (tbl[i].chk_rd) check($sformatf("vec%0d.prdata", i), 64'(rd), 64'(tbl[i].exp_rd));
  endtask

  initial begin
    logic [31:0] rd;
    logic err;

    for (int i = 0; i < 7; i++) tbl[i] = '{1'b0, 12'(i * 4), 32'd0, 1'b1, 32'd0, 1'b0};
    tbl[7]  = '{1'b1, 12'h004, 32'h0000_0100, 1'b0, 32'd0, 1'b0};
    tbl[8]  = '{1'b1, 12'h008, 32'h0000_0AB0, 1'b0, 32'd0, 1'b0};
    tbl[9]  = '{1'b0, 12'h008, 32'd0, 1'b1, 32'h0000_0AB0, 1'b0};
    tbl[10] = '{1'b1, 12'h008, 32'h0000_0000, 1'b0, 32'd0, 1'b0};
    tbl[11] = '{1'b1, 12'h00C, 32'h8000_0000, 1'b0, 32'd0, 1'b0};
    tbl[12] = '{1'b0, 12'h00C, 32'd0, 1'b1, 32'h8000_0000, 1'b0};
    tbl[13] = '{1'b1, 12'h010, 32'h0000_0005, 1'b0, 32'd0, 1'b0};
    tbl[14] = '{1'b0, 12'h010, 32'd0, 1'b1, 32'h0000_0000, 1'b0};
    tbl[15] = '{1'b1, 12'h014, 32'd64, 1'b0, 32'd0, 1'b0};
    tbl[16] = '{1'b0, 12'h014, 32'd0, 1'b1, 32'd64, 1'b0};
    tbl[17] = '{1'b0, 12'h01C, 32'd0, 1'b1, 32'd0, 1'b1};
    tbl[18] = '{1'b1, 12'h040, 32'hFFFF_FFFF, 1'b0, 32'd0, 1'b1};
    tbl[19] = '{1'b1, 12'h000, 32'h0000_0002, 1'b0, 32'd0, 1'b0};
    tbl[20] = '{1'b0, 12'h000, 32'd0, 1'b1, 32'h0000_0002, 1'b0};
    tbl[21] = '{1'b0, 12'h018, 32'd0, 1'b1, 32'h0000_0000, 1'b0};
    tbl[22] = '{1'b0, 12'h017, 32'd0, 1'b1, 32'd64, 1'b0};

    // Reset state
    repeat (2) @(negedge apb_clk);
    apb_reset_n = 1'b1;
    #1;
    check("reset.cmd_valid", 64'(cmd_valid), 64'd0);
    check("reset.irq", 64'(irq), 64'd0);
    check("reset.pready", 64'(pready), 64'd1);
    check("reset.prdata_idle", 64'(prdata), 64'd0);
    check("reset.pslverr_idle", 64'(pslverr), 64'd0);

    for (int i = 0; i < 23; i++) run_vec(i);

    // Launch with cmd_ready held low, then accept
    wr_reg("cr_start", 12'h000, 32'h3, 1'b0);
    for (int c = 0; c < 3; c++) begin
      @(negedge apb_clk);
      check($sformatf("req%0d.cmd_valid", c), 64'(cmd_valid), 64'd1);
      check($sformatf("req%0d.cmd_src", c), 64'(cmd_src), 64'h100);
      check($sformatf("req%0d.cmd_dst", c), 64'(cmd_dst), 64'h8000_0000);
      check($sformatf("req%0d.cmd_len", c), 64'(cmd_len), 64'd64);
    end
    handshake();
    check("busy.cmd_valid", 64'(cmd_valid), 64'd0);
    rd_chk("busy.sr", 12'h018, 32'h1);

    // Config writes blocked while busy; done beats a same-cycle W1C
    wr_reg("busy_len_wr", 12'h014, 32'd5, 1'b1);
    rd_chk("busy.len", 12'h014, 32'd64);
    apb(1'b1, 12'h018, 32'h2, 1'b1, 1'b0, rd, err);
    check("done_w1c.pslverr", 64'(err), 64'd0);
    check("done.irq_same", 64'(irq), 64'd0);
    @(posedge apb_clk);
    #1;
    check("done.irq_next", 64'(irq), 64'd1);
    rd_chk("done.sr", 12'h018, 32'h2);

    // Zero-length start completes immediately
    wr_reg("sr_clr", 12'h018, 32'h2, 1'b0);
    rd_chk("sr_clr.sr", 12'h018, 32'h0);
    wr_reg("len0", 12'h014, 32'd0, 1'b0);
    wr_reg("cr_len0", 12'h000, 32'h1, 1'b0);
    check("len0.cmd_valid", 64'(cmd_valid), 64'd0);
    rd_chk("len0.sr", 12'h018, 32'h2);
    check("len0.irq_dis", 64'(irq), 64'd0);

    // Error then done
    wr_reg("len8", 12'h014, 32'd8, 1'b0);
    wr_reg("cr_start2", 12'h000, 32'h3, 1'b0);
    handshake();
    rd_chk("err.sr_busy", 12'h018, 32'h1);
    @(negedge apb_clk);
    dma_err = 1'b1;
    @(posedge apb_clk);
    #1;
    dma_err = 1'b0;
    rd_chk("err.sr", 12'h018, 32'h5);
    check("err.irq", 64'(irq), 64'd1);
    @(negedge apb_clk);
    dma_done = 1'b1;
    @(posedge apb_clk);
    #1;
    dma_done = 1'b0;
    rd_chk("err_done.sr", 12'h018, 32'h6);
    apb(1'b1, 12'h018, 32'h6, 1'b0, 1'b0, rd, err);
    check("w1c.irq_same", 64'(irq), 64'd1);
    @(posedge apb_clk);
    #1;
    check("w1c.irq_next", 64'(irq), 64'd0);
    rd_chk("w1c.sr", 12'h018, 32'h0);

    // Asynchronous reset during REQ
    wr_reg("len4", 12'h014, 32'd4, 1'b0);
    wr_reg("cr_start3", 12'h000, 32'h1, 1'b0);
    check("req3.cmd_valid", 64'(cmd_valid), 64'd1);
    @(negedge apb_clk);
    apb_reset_n = 1'b0;
    #1;
    check("arst.cmd_valid", 64'(cmd_valid), 64'd0);
    check("arst.irq", 64'(irq), 64'd0);
    @(negedge apb_clk);
    apb_reset_n = 1'b1;
    for (int i = 0; i < 7; i++) run_vec(i);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
